// File: rtl/imem_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_stream_loader
// Purpose  : Boot-time instruction-memory writer. Accepts a byte stream
//            (4-byte LE word count N, 4*N LE payload bytes, 1 XOR checksum
//            byte), writes each assembled word to imem address 4*k and holds
//            the CPU core in reset until the whole image is checksum-verified.
// Ports    : pll_1_200MHz        - clock (rising edge)
//            pll_1_locked_synced - asynchronous active-low reset
//            rx_byte_valid/data  - incoming byte, rx_byte_ready - accept
//            imem_write_*        - single-cycle instruction-memory write port
//            cpu_reset_n         - core reset, released on verified load
//            load_done/error     - sticky completion / failure flags
// Revision : 1.0 - initial release
// ============================================================================
module imem_stream_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        pll_1_200MHz,
  input  logic        pll_1_locked_synced,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte_data,
  output logic        rx_byte_ready,
  output logic        imem_write_enable,
  output logic [31:0] imem_write_address,
  output logic [31:0] imem_write_data,
  output logic        cpu_reset_n,
  output logic        load_done,
  output logic        load_error
);

  typedef enum logic [2:0] {
    S_HEADER  = 3'd0,
    S_PAYLOAD = 3'd1,
    S_CHECK   = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  // Image capacity in words; 33 bits so the 32-bit count compares unsigned
  // without overflow.
  localparam logic [32:0] c_CAPACITY = 33'd1 << ADDR_WIDTH;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_ready;
  logic [1:0]          r_lane;
  logic [23:0]         r_assembly;
  logic [ADDR_WIDTH:0] r_word_idx;
  logic [ADDR_WIDTH:0] r_last_idx;
  logic [7:0]          r_xor;
  logic                r_write_enable;
  logic [31:0]         r_write_address;
  logic [31:0]         r_write_data;
  logic                r_cpu_reset_n;
  logic                r_done;
  logic                r_error;

  logic                w_accept;
  logic                w_lane_last;
  logic [31:0]         w_word;
  logic [31:0]         w_addr;

  assign w_accept    = rx_byte_valid && r_ready;
  assign w_lane_last = (r_lane == 2'd3);
  // The 4th byte completes the word directly from the input, so the write
  // strobe lands exactly one cycle after it is accepted.
  assign w_word      = {rx_byte_data, r_assembly};

  always_comb begin
    w_addr = '0;
    w_addr[ADDR_WIDTH+1:2] = r_word_idx[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge pll_1_200MHz or negedge pll_1_locked_synced) begin
    if (!pll_1_locked_synced) begin
      r_state <= S_HEADER;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HEADER: begin
        if (w_accept && w_lane_last) begin
          if (w_word == 32'd0) begin
            w_next_state = S_CHECK;
          end else if ({1'b0, w_word} > c_CAPACITY) begin
            w_next_state = S_ERROR;
          end else begin
            w_next_state = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_accept && w_lane_last && (r_word_idx == r_last_idx)) begin
          w_next_state = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_accept) begin
          w_next_state = (rx_byte_data == r_xor) ? S_DONE : S_ERROR;
        end
      end
      default: w_next_state = r_state;
    endcase
  end

  always_ff @(posedge pll_1_200MHz or negedge pll_1_locked_synced) begin
    if (!pll_1_locked_synced) begin
      r_ready         <= 1'b0;
      r_lane          <= '0;
      r_assembly      <= '0;
      r_word_idx      <= '0;
      r_last_idx      <= '0;
      r_xor           <= '0;
      r_write_enable  <= 1'b0;
      r_write_address <= '0;
      r_write_data    <= '0;
      r_cpu_reset_n   <= 1'b0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      // Status outputs follow the next state so they are registered yet
      // appear one cycle after the deciding byte.
      r_ready        <= (w_next_state == S_HEADER) || (w_next_state == S_PAYLOAD) ||
                        (w_next_state == S_CHECK);
      r_done         <= (w_next_state == S_DONE);
      r_cpu_reset_n  <= (w_next_state == S_DONE);
      r_error        <= (w_next_state == S_ERROR);
      r_write_enable <= 1'b0;

      if (w_accept && ((r_state == S_HEADER) || (r_state == S_PAYLOAD))) begin
        r_lane <= r_lane + 2'd1;
        case (r_lane)
          2'd0:    r_assembly[7:0]   <= rx_byte_data;
          2'd1:    r_assembly[15:8]  <= rx_byte_data;
          2'd2:    r_assembly[23:16] <= rx_byte_data;
          default: r_assembly        <= r_assembly;
        endcase
      end

      if (w_accept && (r_state == S_HEADER) && w_lane_last) begin
        // Only meaningful for 1 <= N <= capacity, where N-1 fits exactly.
        r_last_idx <= w_word[ADDR_WIDTH:0] - {{ADDR_WIDTH{1'b0}}, 1'b1};
      end

      if (w_accept && (r_state == S_PAYLOAD)) begin
        r_xor <= r_xor ^ rx_byte_data;
        if (w_lane_last) begin
          r_write_enable  <= 1'b1;
          r_write_address <= w_addr;
          r_write_data    <= w_word;
          r_word_idx      <= r_word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
      end
    end
  end

  assign rx_byte_ready      = r_ready;
  assign imem_write_enable  = r_write_enable;
  assign imem_write_address = r_write_address;
  assign imem_write_data    = r_write_data;
  assign cpu_reset_n        = r_cpu_reset_n;
  assign load_done          = r_done;
  assign load_error         = r_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_stream_loader
// Purpose  : Directed self-checking bench for imem_stream_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        rx_byte_ready;
  logic        imem_write_enable;
  logic [31:0] imem_write_address;
  logic [31:0] imem_write_data;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_error;

  imem_stream_loader #(.ADDR_WIDTH(10)) dut (
    .pll_1_200MHz        (clk),
    .pll_1_locked_synced (rst_n),
    .rx_byte_valid       (valid),
    .rx_byte_data        (data),
    .rx_byte_ready       (rx_byte_ready),
    .imem_write_enable   (imem_write_enable),
    .imem_write_address  (imem_write_address),
    .imem_write_data     (imem_write_data),
    .cpu_reset_n         (cpu_reset_n),
    .load_done           (load_done),
    .load_error          (load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  always @(negedge clk) begin
    if (imem_write_enable === 1'b1) begin
      wr_addr_q.push_back(imem_write_address);
      wr_data_q.push_back(imem_write_data);
      wr_cyc_q.push_back(cyc);
    end
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;
  bit gaps   = 1'b0;
  logic [7:0]  stream[$];
  logic [31:0] exp_words[1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int bound = 0;
    if (gaps) begin
      int g = $urandom_range(0, 2);
      repeat (g) @(negedge clk);
    end
    valid = 1'b1;
    data  = b;
    while (rx_byte_ready !== 1'b1 && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    if (bound >= 50) begin
      chk("ready_timeout", {31'd0, rx_byte_ready}, 32'd1);
      valid = 1'b0;
      return;
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic send_stream();
    foreach (stream[i]) send_byte(stream[i]);
  endtask

  task automatic do_reset();
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_nominal_body();
    stream = '{8'h02, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h50, 8'h00,
               8'h33, 8'h81, 8'h10, 8'h00};
  endtask

  task automatic run_nominal();
    load_nominal_body();
    send_stream();
    chk("nom_done_before_cksum", {31'd0, load_done}, 32'd0);
    chk("nom_cpurst_before_cksum", {31'd0, cpu_reset_n}, 32'd0);
    send_byte(8'h61);
    chk("nom_done", {31'd0, load_done}, 32'd1);
    chk("nom_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd1);
    chk("nom_error", {31'd0, load_error}, 32'd0);
    chk("nom_ready_after", {31'd0, rx_byte_ready}, 32'd0);
    @(negedge clk);
    chk("nom_write_count", wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) begin
      chk("nom_addr0", wr_addr_q[0], 32'h0000_0000);
      chk("nom_data0", wr_data_q[0], 32'h0050_0093);
      chk("nom_addr1", wr_addr_q[1], 32'h0000_0004);
      chk("nom_data1", wr_data_q[1], 32'h0010_8133);
      chk("nom_strobe_spacing", wr_cyc_q[1] - wr_cyc_q[0], 32'd4);
    end
  endtask

  initial begin
    logic [7:0] cks;
    int bad;
    int n;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, rx_byte_ready}, 32'd0);
    chk("rst_we", {31'd0, imem_write_enable}, 32'd0);
    chk("rst_addr", imem_write_address, 32'd0);
    chk("rst_data", imem_write_data, 32'd0);
    chk("rst_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);
    chk("rst_done", {31'd0, load_done}, 32'd0);
    chk("rst_error", {31'd0, load_error}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {31'd0, rx_byte_ready}, 32'd1);

    // Nominal 2-word load, valid held high
    run_nominal();

    // Bytes presented in DONE are ignored
    valid = 1'b1;
    data  = 8'hAA;
    repeat (4) @(negedge clk);
    valid = 1'b0;
    chk("done_ignore_writes", wr_addr_q.size(), 32'd2);
    chk("done_sticky", {31'd0, load_done}, 32'd1);

    // Checksum mismatch
    do_reset();
    load_nominal_body();
    send_stream();
    send_byte(8'h62);
    chk("mis_error", {31'd0, load_error}, 32'd1);
    chk("mis_done", {31'd0, load_done}, 32'd0);
    chk("mis_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);
    @(negedge clk);
    chk("mis_write_count", wr_addr_q.size(), 32'd2);

    // Empty image, good checksum
    do_reset();
    stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_stream();
    chk("empty_done", {31'd0, load_done}, 32'd1);
    chk("empty_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd1);
    @(negedge clk);
    chk("empty_writes", wr_addr_q.size(), 32'd0);

    // Empty image, bad checksum
    do_reset();
    stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    send_stream();
    chk("empty_bad_error", {31'd0, load_error}, 32'd1);
    chk("empty_bad_done", {31'd0, load_done}, 32'd0);

    // Oversize count N = 1025
    do_reset();
    stream = '{8'h01, 8'h04, 8'h00, 8'h00};
    send_stream();
    chk("over_error", {31'd0, load_error}, 32'd1);
    chk("over_ready", {31'd0, rx_byte_ready}, 32'd0);
    chk("over_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);
    repeat (2) @(negedge clk);
    chk("over_writes", wr_addr_q.size(), 32'd0);

    // Full-capacity 1024-word image with random valid gaps
    do_reset();
    gaps = 1'b1;
    cks = 8'h00;
    stream = '{8'h00, 8'h04, 8'h00, 8'h00};
    for (int k = 0; k < 1024; k++) begin
      exp_words[k] = $urandom;
      for (int b = 0; b < 4; b++) begin
        stream.push_back(exp_words[k][8*b +: 8]);
        cks = cks ^ exp_words[k][8*b +: 8];
      end
    end
    stream.push_back(cks);
    send_stream();
    gaps = 1'b0;
    chk("big_done", {31'd0, load_done}, 32'd1);
    chk("big_error", {31'd0, load_error}, 32'd0);
    repeat (2) @(negedge clk);
    chk("big_write_count", wr_addr_q.size(), 32'd1024);
    n = (wr_addr_q.size() < 1024) ? wr_addr_q.size() : 1024;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (wr_data_q[k] !== exp_words[k] || wr_addr_q[k] !== 32'(k * 4)) bad++;
    end
    chk("big_word_mismatches", bad, 32'd0);
    if (wr_addr_q.size() > 0) chk("big_last_addr", wr_addr_q[wr_addr_q.size()-1], 32'h0000_0FFC);

    // Reset mid-operation: after 2 bytes of word 1
    do_reset();
    stream = '{8'h02, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h50, 8'h00,
               8'h33, 8'h81};
    send_stream();
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, rx_byte_ready}, 32'd0);
    chk("midrst_we", {31'd0, imem_write_enable}, 32'd0);
    chk("midrst_addr", imem_write_address, 32'd0);
    chk("midrst_data", imem_write_data, 32'd0);
    chk("midrst_cpu_reset_n", {31'd0, cpu_reset_n}, 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_write_count", wr_addr_q.size(), 32'd1);
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    run_nominal();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
